// File: rtl/estimador_seq_pkg.sv
// estimador_seq_pkg: shared state encoding and default sizing for the estimator loop sequencer.
package estimador_seq_pkg;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN, SEQ_DONE} seq_state_e;
  localparam int unsigned SEQ_CNT_W = 16;
  localparam int unsigned SEQ_MAX_INFLIGHT = 8;
  localparam int unsigned SEQ_INF_W = 4;
endpackage

// File: rtl/estimador_seq_inflight_cnt.sv
// estimador_seq_inflight_cnt: issued-minus-retired counter, saturating at 0, with sticky retire-underflow flag.
module estimador_seq_inflight_cnt
  import estimador_seq_pkg::*;
#(
  parameter int unsigned INF_W = SEQ_INF_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [INF_W-1:0] cnt_o,
  output logic             err_o,
  output logic             dec_ok_o
);
  logic [INF_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  always_comb begin
    dec_ok_o = dec_i & (cnt_q != '0);
    cnt_d = clr_i ? '0 :
            (inc_i & ~dec_i) ? cnt_q + 1'b1 :
            (dec_ok_o & ~inc_i) ? cnt_q - 1'b1 : cnt_q;
    err_d = err_q | (dec_i & (cnt_q == '0));
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/estimador_loop_sequencer.sv
// estimador_loop_sequencer: issues a runtime trip count of loop-body iterations with bounded in-flight depth.
// Optional performance counters (run_cycles, stall_cycles) under `ESTIMADOR_SEQ_PERF_EN.
module estimador_loop_sequencer
  import estimador_seq_pkg::*;
#(
  parameter int unsigned CNT_W        = SEQ_CNT_W,
  parameter int unsigned MAX_INFLIGHT = SEQ_MAX_INFLIGHT,
  parameter int unsigned INF_W        = SEQ_INF_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic             ap_continue,
  input  logic [CNT_W-1:0] trip_count,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             body_start,
  input  logic             body_ready,
  input  logic             body_iter_done,
  output logic [CNT_W-1:0] iter_idx,
  output logic             loop_init,
  output logic             loop_last,
  output logic [INF_W-1:0] inflight,
  output logic             err_retire
`ifdef ESTIMADOR_SEQ_PERF_EN
  ,
  output logic [31:0]      run_cycles,
  output logic [31:0]      stall_cycles
`endif
);
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] trip_q, trip_d, issued_q, issued_d, retired_q, retired_d, retired_nx;
  logic             accept, issue, retire, dec_ok;

  assign retire = body_iter_done & (state_q != SEQ_IDLE);

  estimador_seq_inflight_cnt #(.INF_W(INF_W)) u_inflight (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr_i    (accept),
    .inc_i    (issue),
    .dec_i    (retire),
    .cnt_o    (inflight),
    .err_o    (err_retire),
    .dec_ok_o (dec_ok)
  );

  always_comb begin
    accept     = ap_start & ((state_q == SEQ_IDLE) | ((state_q == SEQ_DONE) & ap_continue));
    body_start = (state_q == SEQ_RUN) & (issued_q < trip_q) & (inflight < INF_W'(MAX_INFLIGHT));
    issue      = body_start & body_ready;
    loop_init  = body_start & (issued_q == '0);
    loop_last  = body_start & (issued_q == trip_q - 1'b1);
    iter_idx   = (state_q == SEQ_RUN) ? issued_q : '0;
    ap_idle    = state_q == SEQ_IDLE;
    ap_done    = state_q == SEQ_DONE;
    ap_ready   = (issue & loop_last) | (accept & (trip_count == '0));
    retired_nx = retired_q + CNT_W'(dec_ok);
    trip_d     = accept ? trip_count : trip_q;
    issued_d   = accept ? '0 : issued_q + CNT_W'(issue);
    retired_d  = accept ? '0 : retired_nx;
    state_d    = state_q;
    // Accept has priority so DONE can restart directly without passing through IDLE.
    if (accept) state_d = (trip_count == '0) ? SEQ_DONE : SEQ_RUN;
    else if ((state_q == SEQ_RUN) & issue & loop_last) state_d = SEQ_DRAIN;
    else if ((state_q == SEQ_DRAIN) & (retired_nx == trip_q)) state_d = SEQ_DONE;
    else if ((state_q == SEQ_DONE) & ap_continue) state_d = SEQ_IDLE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= SEQ_IDLE;
      trip_q    <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      trip_q    <= trip_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
    end
  end

`ifdef ESTIMADOR_SEQ_PERF_EN
  logic [31:0] run_q, run_d, stall_q, stall_d;
  always_comb begin
    run_d   = accept ? '0 :
              (((state_q == SEQ_RUN) | (state_q == SEQ_DRAIN)) & (run_q != '1)) ? run_q + 32'd1 : run_q;
    stall_d = stall_q + 32'((state_q == SEQ_RUN) & (issued_q < trip_q) &
              ((inflight == INF_W'(MAX_INFLIGHT)) | (body_start & ~body_ready)));
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      run_q   <= '0;
      stall_q <= '0;
    end else begin
      run_q   <= run_d;
      stall_q <= stall_d;
    end
  end
  assign run_cycles   = run_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_estimador_loop_sequencer.sv
// tb_estimador_loop_sequencer: randomized stimulus with a queue scoreboard and a cycle-level reference model.
module tb_estimador_loop_sequencer;
  localparam int CW = 16, MI = 4, IW = 4;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0, ap_continue = 1'b0;
  logic body_ready = 1'b0, body_iter_done = 1'b0;
  logic [CW-1:0] trip_count = '0;
  logic ap_idle, ap_ready, ap_done, body_start, loop_init, loop_last, err_retire;
  logic [CW-1:0] iter_idx;
  logic [IW-1:0] inflight;
`ifdef ESTIMADOR_SEQ_PERF_EN
  logic [31:0] run_cycles, stall_cycles;
`endif
  int errors = 0, checks = 0, cyc = 0, lat = 3;
  int ph = 0, m_trip = 0, m_iss = 0, m_ret = 0, m_inf = 0;
  bit auto_m = 1'b1, iss, m_err = 1'b0, m_bs, m_is, m_ac, m_rt, m_dk;
  bit ret_sched[int];
  typedef struct {int idx; bit init; bit last;} rec_t;
  rec_t exp_q[$];
  rec_t r;

  always #5 ap_clk = ~ap_clk;

  estimador_loop_sequencer #(.CNT_W(CW), .MAX_INFLIGHT(MI), .INF_W(IW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .trip_count(trip_count), .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .body_start(body_start), .body_ready(body_ready), .body_iter_done(body_iter_done),
    .iter_idx(iter_idx), .loop_init(loop_init), .loop_last(loop_last),
    .inflight(inflight), .err_retire(err_retire)
`ifdef ESTIMADOR_SEQ_PERF_EN
    , .run_cycles(run_cycles), .stall_cycles(stall_cycles)
`endif
  );

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // Monitor: the model phase is 0 idle, 1 active (issuing or draining), 2 done.
  always @(negedge ap_clk) begin
    #2;
    if (!ap_rst_n) begin
      chk("rst_body_start", 32'(body_start), 0);
      chk("rst_ap_idle", 32'(ap_idle), 1);
      chk("rst_ap_done", 32'(ap_done), 0);
      chk("rst_ap_ready", 32'(ap_ready), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_err_retire", 32'(err_retire), 0);
      chk("rst_iter_idx", 32'(iter_idx), 0);
      ph = 0; m_trip = 0; m_iss = 0; m_ret = 0; m_inf = 0; m_err = 1'b0;
    end else begin
      m_bs = ph == 1 && m_iss < m_trip && m_inf < MI;
      m_is = m_bs && body_ready;
      m_ac = ap_start && (ph == 0 || (ph == 2 && ap_continue));
      m_rt = body_iter_done && ph != 0;
      chk("body_start", 32'(body_start), 32'(m_bs));
      chk("ap_idle", 32'(ap_idle), 32'(ph == 0));
      chk("ap_done", 32'(ap_done), 32'(ph == 2));
      chk("inflight", 32'(inflight), 32'(m_inf));
      chk("err_retire", 32'(err_retire), 32'(m_err));
      chk("ap_ready", 32'(ap_ready), 32'((m_is && m_iss == m_trip - 1) || (m_ac && trip_count == '0)));
      if (m_is) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: iter_idx=%0d issued, expected no pending iteration", iter_idx);
        end else begin
          r = exp_q.pop_front();
          chk("iter_idx", 32'(iter_idx), 32'(r.idx));
          chk("loop_init", 32'(loop_init), 32'(r.init));
          chk("loop_last", 32'(loop_last), 32'(r.last));
        end
      end
      if (m_rt && m_inf == 0) m_err = 1'b1;
      m_dk = m_rt && m_inf > 0;
      if (m_ac) begin
        m_trip = int'(trip_count); m_iss = 0; m_ret = 0; m_inf = 0;
        ph = (trip_count == '0) ? 2 : 1;
      end else begin
        m_iss += int'(m_is);
        m_ret += int'(m_dk);
        m_inf += (m_is && !m_rt) ? 1 : (m_dk && !m_is) ? -1 : 0;
        if (ph == 1 && m_iss == m_trip && m_ret == m_trip) ph = 2;
        else if (ph == 2 && ap_continue) ph = 0;
      end
    end
  end

  task automatic step(input bit rd, input bit rt, input bit st, input bit ct, input int tc);
    @(negedge ap_clk);
    cyc++;
    body_ready = rd; ap_start = st; ap_continue = ct;
    trip_count = st ? CW'(tc) : CW'($urandom);
    body_iter_done = rt || (auto_m && ret_sched.exists(cyc));
    if (ret_sched.exists(cyc)) ret_sched.delete(cyc);
    #1;
    iss = body_start && body_ready;
    if (auto_m && iss) begin
      int t = cyc + lat;
      while (ret_sched.exists(t)) t++;
      ret_sched[t] = 1'b1;
    end
  endtask

  task automatic invoke(input int t, input bit ct);
    for (int i = 0; i < t; i++) exp_q.push_back('{i, i == 0, i == t - 1});
    step(1'b1, 1'b0, 1'b1, ct, t);
  endtask

  task automatic run_auto(input int t, input int l, input int pct);
    auto_m = 1'b1; lat = l;
    for (int k = 0; k < 300 && !(ap_idle || ap_done); k++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    invoke(t, ap_done);
    step($urandom_range(99) < pct, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3000 && !ap_done; k++) step($urandom_range(99) < pct, 1'b0, 1'b0, 1'b0, 0);
    chk("run_reaches_done", 32'(ap_done), 1);
  endtask

  initial begin
    int n, outst;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    ap_rst_n = 1'b1;
    // Consecutive issue of 5 iterations, fixed latency 3.
    run_auto(5, 3, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Depth bound: 12 iterations, nothing retires for 10 cycles.
    auto_m = 1'b0;
    invoke(12, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      n += int'(iss);
    end
    chk("depth_issue_count", 32'(n), MI);
    chk("depth_inflight", 32'(inflight), MI);
    outst = n;
    for (int k = 0; k < 200 && !ap_done; k++) begin
      step(1'b1, (k % 2 == 0) && outst > 0, 1'b0, 1'b0, 0);
      outst += int'(iss) - int'(body_iter_done);
    end
    chk("depth_done", 32'(ap_done), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Zero trip count, then acknowledge back to idle.
    invoke(0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("zero_trip_done", 32'(ap_done), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("zero_trip_idle", 32'(ap_idle), 1);
    // Direct restart from DONE with trip 3.
    invoke(0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_auto(3, 2, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Same-cycle issue and retire, then a retire with nothing in flight.
    auto_m = 1'b0;
    invoke(4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("same_cycle_inflight", 32'(inflight), 2);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("err_retire_set", 32'(err_retire), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("err_retire_sticky", 32'(err_retire), 1);
    // Randomized invocations, sometimes restarting directly from DONE.
    for (int j = 0; j < 8; j++) begin
      if (ap_done && $urandom_range(1) == 1) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      run_auto($urandom_range(20), $urandom_range(1, 7), $urandom_range(50, 100));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Asynchronous reset in the middle of a 6-iteration run.
    auto_m = 1'b1; lat = 20;
    invoke(6, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("pre_reset_body_start", 32'(body_start), 1);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk("reset_drops_body_start", 32'(body_start), 0);
    exp_q.delete();
    ret_sched.delete();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    ap_rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("post_reset_idle", 32'(ap_idle), 1);
    chk("post_reset_err", 32'(err_retire), 0);
    run_auto(2, 2, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
